// File: rtl/voice_scheduler.sv
// Voice table owner and per-sample frame sequencer for the polyphonic voice path.
// Between frames it serves note-on/off requests: allocate, retrigger or steal a slot, and emit a cfg write.
module voice_scheduler #(
    parameter int NUM_VOICES = 10,
    parameter int IDX_W      = 4,
    parameter int NOTE_W     = 7,
    parameter int AGE_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sample_tick,
    input  logic              i_note_valid,
    output logic              o_note_ready,
    input  logic              i_note_on,
    input  logic [NOTE_W-1:0] i_note,
    output logic              o_voice_en,
    output logic [IDX_W-1:0]  o_voice_idx,
    output logic              o_voice_active,
    output logic [NOTE_W-1:0] o_voice_note,
    output logic              o_frame_done,
    output logic              o_overrun,
    output logic              o_cfg_we,
    output logic [IDX_W-1:0]  o_cfg_idx,
    output logic [NOTE_W-1:0] o_cfg_note,
    output logic              o_cfg_gate
);
    // state | meaning
    // IDLE  | between frames; a pending tick wins over a note request
    // ALLOC | one cycle applying the latched note request to the table
    // SCAN  | presents slots 0..NUM_VOICES-1, one per cycle, to the mixer
    // DONE  | one cycle with o_frame_done high
    typedef enum logic [1:0] {IDLE, ALLOC, SCAN, DONE} state_t;

    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t                  state;
    logic                    pend;
    logic                    ready_q;
    logic                    req_on;
    logic [NOTE_W-1:0]       req_note;
    logic [NUM_VOICES-1:0]   gate;
    logic [NOTE_W-1:0]       note_tab [NUM_VOICES];
    logic [AGE_W-1:0]        age_tab  [NUM_VOICES];

    logic                    match_found;
    logic [IDX_W-1:0]        match_idx;
    logic [NUM_VOICES-1:0]   match_mask;
    logic                    free_found;
    logic [IDX_W-1:0]        free_idx;
    logic [IDX_W-1:0]        old_idx;
    logic [AGE_W-1:0]        old_age;
    logic [IDX_W-1:0]        tgt_idx;
    logic [IDX_W-1:0]        nxt_idx;
    logic                    accept;

    // The tick must block the handshake in the same cycle it arrives, so ready is gated combinationally.
    assign o_note_ready = ready_q && !i_sample_tick;
    assign accept       = i_note_valid && o_note_ready;
    assign nxt_idx      = o_voice_idx + IDX_W'(1);

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        match_mask  = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        old_idx     = '0;
        old_age     = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate[i] && note_tab[i] == req_note) begin
                match_mask[i] = 1'b1;
                if (!match_found) begin
                    match_found = 1'b1;
                    match_idx   = IDX_W'(i);
                end
            end
            if (!gate[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            // Strict compare keeps the lowest index on equal ages.
            if (age_tab[i] > old_age) begin
                old_age = age_tab[i];
                old_idx = IDX_W'(i);
            end
        end
        if (match_found)
            tgt_idx = match_idx;
        else if (free_found)
            tgt_idx = free_idx;
        else
            tgt_idx = old_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pend           <= 1'b0;
            ready_q        <= 1'b1;
            req_on         <= 1'b0;
            req_note       <= '0;
            gate           <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_tab[i] <= '0;
                age_tab[i]  <= '0;
            end
            o_voice_en     <= 1'b0;
            o_voice_idx    <= '0;
            o_voice_active <= 1'b0;
            o_voice_note   <= '0;
            o_frame_done   <= 1'b0;
            o_overrun      <= 1'b0;
            o_cfg_we       <= 1'b0;
            o_cfg_idx      <= '0;
            o_cfg_note     <= '0;
            o_cfg_gate     <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_cfg_we     <= 1'b0;
            o_overrun    <= i_sample_tick && pend;
            pend         <= pend || i_sample_tick;
            case (state)
                IDLE: begin
                    if (pend || i_sample_tick) begin
                        pend           <= 1'b0;
                        ready_q        <= 1'b0;
                        state          <= SCAN;
                        o_voice_en     <= 1'b1;
                        o_voice_idx    <= '0;
                        o_voice_active <= gate[0];
                        o_voice_note   <= note_tab[0];
                    end else if (accept) begin
                        req_on   <= i_note_on;
                        req_note <= i_note;
                        ready_q  <= 1'b0;
                        state    <= ALLOC;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ALLOC: begin
                    state   <= IDLE;
                    ready_q <= !(pend || i_sample_tick);
                    if (req_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == tgt_idx) begin
                                gate[i]     <= 1'b1;
                                note_tab[i] <= req_note;
                                age_tab[i]  <= '0;
                            end else if (gate[i] && age_tab[i] != AGE_MAX) begin
                                age_tab[i] <= age_tab[i] + AGE_W'(1);
                            end
                        end
                        o_cfg_we   <= 1'b1;
                        o_cfg_idx  <= tgt_idx;
                        o_cfg_note <= req_note;
                        o_cfg_gate <= 1'b1;
                    end else if (match_found) begin
                        gate       <= gate & ~match_mask;
                        o_cfg_we   <= 1'b1;
                        o_cfg_idx  <= match_idx;
                        o_cfg_note <= req_note;
                        o_cfg_gate <= 1'b0;
                    end
                end
                SCAN: begin
                    ready_q <= 1'b0;
                    if (o_voice_idx == LAST_IDX) begin
                        state          <= DONE;
                        o_frame_done   <= 1'b1;
                        o_voice_en     <= 1'b0;
                        o_voice_idx    <= '0;
                        o_voice_active <= 1'b0;
                        o_voice_note   <= '0;
                    end else begin
                        o_voice_idx    <= nxt_idx;
                        o_voice_active <= gate[nxt_idx];
                        o_voice_note   <= note_tab[nxt_idx];
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= !(pend || i_sample_tick);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: directed scenarios plus random note/frame traffic
// compared against a slot-table model built from the allocation rules.
module tb_voice_scheduler;
    localparam int NV = 10;
    localparam int IW = 4;
    localparam int NW = 7;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_sample_tick = 1'b0;
    logic          i_note_valid = 1'b0;
    logic          o_note_ready;
    logic          i_note_on = 1'b0;
    logic [NW-1:0] i_note = '0;
    logic          o_voice_en;
    logic [IW-1:0] o_voice_idx;
    logic          o_voice_active;
    logic [NW-1:0] o_voice_note;
    logic          o_frame_done;
    logic          o_overrun;
    logic          o_cfg_we;
    logic [IW-1:0] o_cfg_idx;
    logic [NW-1:0] o_cfg_note;
    logic          o_cfg_gate;

    voice_scheduler #(.NUM_VOICES(NV), .IDX_W(IW), .NOTE_W(NW), .AGE_W(AW)) dut (
        .clk(clk), .rst(rst), .i_sample_tick(i_sample_tick),
        .i_note_valid(i_note_valid), .o_note_ready(o_note_ready),
        .i_note_on(i_note_on), .i_note(i_note),
        .o_voice_en(o_voice_en), .o_voice_idx(o_voice_idx),
        .o_voice_active(o_voice_active), .o_voice_note(o_voice_note),
        .o_frame_done(o_frame_done), .o_overrun(o_overrun),
        .o_cfg_we(o_cfg_we), .o_cfg_idx(o_cfg_idx),
        .o_cfg_note(o_cfg_note), .o_cfg_gate(o_cfg_gate)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_gate [NV];
    int m_note [NV];
    int m_age  [NV];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0;
            m_note[i] = 0;
            m_age[i]  = 0;
        end
    endtask

    function automatic int model_on(input int n);
        int t;
        int best;
        t = -1;
        for (int i = 0; i < NV; i++)
            if (t < 0 && m_gate[i] != 0 && m_note[i] == n) t = i;
        for (int i = 0; i < NV; i++)
            if (t < 0 && m_gate[i] == 0) t = i;
        if (t < 0) begin
            best = -1;
            for (int i = 0; i < NV; i++)
                if (m_age[i] > best) begin
                    best = m_age[i];
                    t = i;
                end
        end
        for (int i = 0; i < NV; i++)
            if (i != t && m_gate[i] != 0 && m_age[i] < (1 << AW) - 1) m_age[i]++;
        m_gate[t] = 1;
        m_note[t] = n;
        m_age[t]  = 0;
        return t;
    endfunction

    function automatic int model_off(input int n);
        int t;
        t = -1;
        for (int i = 0; i < NV; i++)
            if (m_gate[i] != 0 && m_note[i] == n) begin
                if (t < 0) t = i;
                m_gate[i] = 0;
            end
        return t;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_async_en", o_voice_en, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {o_voice_en, o_voice_idx, o_voice_active, o_voice_note, o_frame_done,
               o_overrun, o_cfg_we, o_cfg_idx, o_cfg_note, o_cfg_gate}, 0);
        check("reset_ready", o_note_ready, 1);
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic send_note(input bit on, input int n, output int waited, output int cfg_idx);
        int t;
        i_note_valid = 1'b1;
        i_note_on    = on;
        i_note       = NW'(n);
        waited = 0;
        while (!o_note_ready && waited < 50) begin
            step();
            waited++;
        end
        check("note_ready_timeout", (waited < 50), 1);
        step();
        i_note_valid = 1'b0;
        check("ready_in_alloc", o_note_ready, 0);
        step();
        cfg_idx = o_cfg_idx;
        if (on) begin
            t = model_on(n);
            check("cfg_on", {o_cfg_we, o_cfg_idx, o_cfg_note, o_cfg_gate},
                  {1'b1, IW'(t), NW'(n), 1'b1});
        end else begin
            t = model_off(n);
            if (t < 0)
                check("cfg_off_absent", o_cfg_we, 0);
            else
                check("cfg_off", {o_cfg_we, o_cfg_idx, o_cfg_note, o_cfg_gate},
                      {1'b1, IW'(t), NW'(n), 1'b0});
        end
    endtask

    // Extra ticks can be injected while slot tick_a / tick_b is on the bus.
    task automatic scan_slots(input int count, input int tick_a, input int tick_b);
        bit exp_ov;
        for (int i = 0; i < count; i++) begin
            exp_ov = (tick_a >= 0 && tick_b >= 0 && i == tick_b + 1);
            check("scan_slot",
                  {o_overrun, o_note_ready, o_voice_en, o_voice_idx, o_voice_active, o_voice_note},
                  {exp_ov, 1'b0, 1'b1, IW'(i), 1'(m_gate[i]), NW'(m_note[i])});
            i_sample_tick = (i == tick_a || i == tick_b);
            step();
        end
        i_sample_tick = 1'b0;
    endtask

    task automatic run_frame(input int tick_a, input int tick_b);
        i_sample_tick = 1'b1;
        #1;
        check("ready_low_on_tick", o_note_ready, 0);
        step();
        i_sample_tick = 1'b0;
        scan_slots(NV, tick_a, tick_b);
        check("frame_done", {o_frame_done, o_voice_en, o_note_ready, o_cfg_we}, 4'b1000);
        step();
        check("after_done", {o_frame_done, o_voice_en, o_note_ready}, {1'b0, 1'b0, (tick_a < 0)});
    endtask

    initial begin
        int w, idx, cnt;
        model_reset();
        do_reset();

        repeat (3) step();
        run_frame(-1, -1);

        send_note(1, 60, w, idx);
        send_note(1, 64, w, idx);
        check("first_on_idx", idx, 1);
        run_frame(-1, -1);

        do_reset();
        for (int n = 40; n < 50; n++) send_note(1, n, w, idx);
        send_note(1, 50, w, idx);
        check("steal_idx", idx, 0);
        send_note(1, 45, w, idx);
        check("retrigger_idx", idx, 5);
        send_note(0, 47, w, idx);
        check("off_idx", idx, 7);
        send_note(0, 99, w, idx);
        run_frame(-1, -1);

        i_note_valid = 1'b1;
        i_note_on    = 1'b1;
        i_note       = NW'(70);
        run_frame(-1, -1);
        send_note(1, 70, w, idx);
        check("note_after_frame_wait", w, 0);

        for (int k = 0; k < 3; k++) run_frame(-1, -1);

        run_frame(3, 6);
        step();
        check("deferred_start", {o_voice_en, o_voice_idx}, {1'b1, 4'd0});
        scan_slots(4, -1, -1);
        check("pre_reset_idx", {o_voice_en, o_voice_idx}, {1'b1, 4'd4});
        rst = 1'b1;
        #1;
        check("rst_drops_en", o_voice_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            cnt += int'(o_frame_done);
        end
        check("no_done_after_reset", cnt, 0);
        run_frame(-1, -1);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0)
                run_frame(-1, -1);
            else
                send_note($urandom_range(0, 3) != 0, int'($urandom_range(30, 41)), w, idx);
        end
        run_frame(-1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
